// File: rtl/onchip_mem_stream_reader_pkg.sv
// Shared FSM encoding and default sizing for the on-chip RAM stream reader.
package onchip_mem_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam int MEM_WORDS  = 2048;
    localparam int RD_LATENCY = 1;

endpackage

// File: rtl/onchip_mem_stream_reader_fifo.sv
// Two-entry output buffer with fall-through: an arriving RAM word is presented
// on the stream the same cycle when the buffer is empty, and stored otherwise.
module onchip_mem_stream_reader_fifo
    import onchip_mem_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rdPtr_q;
    logic              wrPtr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              empty;
    logic              pop;
    logic              storePush;
    logic              storePop;

    // A word popped straight off the RAM bus never occupies a slot.
    always_comb begin
        empty       = (count_q == 2'd0);
        out_valid_o = !empty || in_valid_i;
        out_data_o  = (empty && in_valid_i) ? in_data_i : mem_q[rdPtr_q];
        pop         = out_valid_o && out_ready_i;
        storePush   = in_valid_i && !(empty && pop);
        storePop    = pop && !empty;
        count_d     = count_q + 2'(storePush) - 2'(storePop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rdPtr_q  <= 1'b0;
            wrPtr_q  <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (storePush) begin
                mem_q[wrPtr_q] <= in_data_i;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (storePop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master streaming a block of on-chip RAM words to a valid/ready sink.
// Define ONCHIP_MEM_STREAM_READER_LOOP_EN to add the loop_en/stop repeat-playback ports.
module onchip_mem_stream_reader
    import onchip_mem_stream_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FIFO_D = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   word_count,
`ifdef ONCHIP_MEM_STREAM_READER_LOOP_EN
    input  logic              loop_en,
    input  logic              stop,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready
);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] startAddr_q;
    logic [ADDR_W:0]   remain_q;
    logic [ADDR_W:0]   remain_d;
    logic [ADDR_W:0]   wordCount_q;
    logic              inflight_q;
    logic              done_q;
    logic [1:0]        fifoCount;
    logic [2:0]        occ_d;
    logic              pop;
    logic              issue;
    logic              lastIssue;
    logic              loopReq;
    logic              stopReq;

`ifdef ONCHIP_MEM_STREAM_READER_LOOP_EN
    assign loopReq = loop_en;
    assign stopReq = stop;
`else
    assign loopReq = 1'b0;
    assign stopReq = 1'b0;
`endif

    // occ_d is buffer occupancy next cycle; a new read only fits if it leaves room for its data.
    always_comb begin
        pop       = src_valid && src_ready;
        occ_d     = 3'(fifoCount) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == ST_RUN) && !stopReq && (occ_d < 3'(FIFO_D));
        lastIssue = issue && (remain_q == (ADDR_W+1)'(1));
        addr_d    = addr_q;
        remain_d  = remain_q;
        if (issue) begin
            if (lastIssue && loopReq) begin
                addr_d   = startAddr_q;
                remain_d = wordCount_q;
            end else begin
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            startAddr_q <= '0;
            remain_q    <= '0;
            wordCount_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ST_RUN;
                            addr_q      <= start_addr;
                            remain_q    <= word_count;
                            startAddr_q <= start_addr;
                            wordCount_q <= word_count;
                        end
                    end
                end
                ST_RUN: begin
                    if (stopReq || (lastIssue && !loopReq)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (occ_d == 3'd0) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign mem_chipselect = issue;
    assign mem_address    = addr_q;

    onchip_mem_stream_reader_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid_i (inflight_q),
        .in_data_i  (mem_readdata),
        .out_valid_o(src_valid),
        .out_data_o (src_data),
        .out_ready_i(src_ready),
        .count_o    (fifoCount)
    );

endmodule
